mux_sel_sequencer: RTL and testbench

MUX_SEL_SEQUENCER -- requirements
Module: mux_sel_sequencer

---
 rtl/mux_sel_pkg.sv | 17 +
 rtl/mux_sel_pulse_timer.sv | 42 ++++
 rtl/mux_sel_sequencer.sv | 174 +++++++++++++++++
 tb/tb_mux_sel_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_sel_pkg.sv
// rtl/mux_sel_pkg.sv - shared types and constants for the mux select sequencer
// Holds the sequencer state encoding and the default design-address width.
package mux_sel_pkg;

    localparam int ADDR_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DISABLE,
        ST_RST_ASSERT,
        ST_RST_RELEASE,
        ST_INC_HI,
        ST_INC_LO,
        ST_ENABLE
    } seq_state_e;

endpackage

// File: rtl/mux_sel_pulse_timer.sv
// rtl/mux_sel_pulse_timer.sv - loadable down-counter timing one control-pulse half-period
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset
//   load_i   in   reload the counter so the next timed state lasts PULSE_CYC cycles
//   expire_o out  high in the last cycle of the current timed state
module mux_sel_pulse_timer #(
    parameter int PULSE_CYC = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    output logic expire_o
);

    localparam int CW = $clog2(PULSE_CYC + 1);
    // Loading PULSE_CYC-1 makes expire_o rise in the PULSE_CYC-th cycle after the load.
    localparam logic [CW-1:0] LOAD_VAL = CW'(PULSE_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= LOAD_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/mux_sel_sequencer.sv
// rtl/mux_sel_sequencer.sv - sequences mux control lines to select a target design address
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   req_valid, req_addr         request to select design req_addr
//   req_ready                   high in IDLE; accept = req_valid && req_ready
//   busy                        high while a select sequence runs
//   done                        one-cycle pulse when the target design is enabled
//   err                         sticky, set by an out-of-range request
//   cur_addr                    currently selected address (valid while ctrl_ena=1)
//   ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena   registered mux control lines
module mux_sel_sequencer
    import mux_sel_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int PULSE_CYC = 2,
    parameter int MAX_ADDR  = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);

    // One extra bit so a MAX_ADDR at or beyond 2**ADDR_W never truncates.
    localparam logic [ADDR_W:0] MAX_EXT = (ADDR_W + 1)'(MAX_ADDR);

    seq_state_e        state_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              rst_n_q;
    logic              inc_q;
    logic              ena_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic              cur_valid_q;
    logic [ADDR_W-1:0] tgt_q;
    logic [ADDR_W-1:0] inc_cnt_q;
    logic              full_q;

    logic timer_load;
    logic timer_expire;
    logic accept;
    logic in_range;
    logic same_addr;
    logic incremental;

    assign accept      = req_valid && ready_q;
    assign in_range    = ({1'b0, req_addr} <= MAX_EXT);
    assign same_addr   = cur_valid_q && (req_addr == cur_addr_q);
    assign incremental = cur_valid_q && (req_addr > cur_addr_q);

    // Every timed state is entered either from IDLE or on the expiry of the
    // previous timed state, so reloading on those cycles times them all.
    assign timer_load = (state_q == ST_IDLE) || timer_expire;

    mux_sel_pulse_timer #(
        .PULSE_CYC (PULSE_CYC)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (timer_load),
        .expire_o (timer_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rst_n_q     <= 1'b1;
            inc_q       <= 1'b0;
            ena_q       <= 1'b0;
            cur_addr_q  <= '0;
            cur_valid_q <= 1'b0;
            tgt_q       <= '0;
            inc_cnt_q   <= '0;
            full_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    if (accept) begin
                        if (!in_range) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q <= 1'b0;
                            if (same_addr) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q   <= ST_DISABLE;
                                ena_q     <= 1'b0;
                                busy_q    <= 1'b1;
                                ready_q   <= 1'b0;
                                tgt_q     <= req_addr;
                                full_q    <= !incremental;
                                inc_cnt_q <= incremental ? (req_addr - cur_addr_q) : req_addr;
                            end
                        end
                    end
                end
                ST_DISABLE: begin
                    // An incremental request always needs at least one pulse.
                    if (timer_expire) begin
                        if (full_q) begin
                            state_q <= ST_RST_ASSERT;
                            rst_n_q <= 1'b0;
                        end else begin
                            state_q <= ST_INC_HI;
                            inc_q   <= 1'b1;
                        end
                    end
                end
                ST_RST_ASSERT: begin
                    if (timer_expire) begin
                        state_q <= ST_RST_RELEASE;
                        rst_n_q <= 1'b1;
                    end
                end
                ST_RST_RELEASE, ST_INC_LO: begin
                    if (timer_expire) begin
                        if (inc_cnt_q == '0) begin
                            state_q     <= ST_ENABLE;
                            ena_q       <= 1'b1;
                            done_q      <= 1'b1;
                            cur_addr_q  <= tgt_q;
                            cur_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_INC_HI;
                            inc_q   <= 1'b1;
                        end
                    end
                end
                ST_INC_HI: begin
                    if (timer_expire) begin
                        state_q   <= ST_INC_LO;
                        inc_q     <= 1'b0;
                        inc_cnt_q <= inc_cnt_q - 1'b1;
                    end
                end
                ST_ENABLE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign cur_addr       = cur_addr_q;
    assign ctrl_sel_rst_n = rst_n_q;
    assign ctrl_sel_inc   = inc_q;
    assign ctrl_ena       = ena_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb/tb_mux_sel_sequencer.sv - directed self-checking bench for mux_sel_sequencer
module tb_mux_sel_sequencer;

    localparam int ADDR_W    = 8;
    localparam int PULSE_CYC = 2;
    localparam int MAX_ADDR  = 200;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              req_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] cur_addr;
    logic              ctrl_sel_rst_n;
    logic              ctrl_sel_inc;
    logic              ctrl_ena;

    int errors = 0;
    int checks = 0;

    int r_done_at;
    int r_rst_low;
    int r_rst_first;
    int r_inc_rise;
    int r_inc_high;
    int r_ena_low;
    int r_edges;
    logic r_err1;
    logic r_busy1;
    logic [ADDR_W-1:0] r_cur;
    logic r_ena_done;

    mux_sel_sequencer #(
        .ADDR_W    (ADDR_W),
        .PULSE_CYC (PULSE_CYC),
        .MAX_ADDR  (MAX_ADDR)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .cur_addr       (cur_addr),
        .ctrl_sel_rst_n (ctrl_sel_rst_n),
        .ctrl_sel_inc   (ctrl_sel_inc),
        .ctrl_ena       (ctrl_ena)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rst_n"}, 32'(ctrl_sel_rst_n), 1);
        chk({tag, "_inc"},   32'(ctrl_sel_inc),   0);
        chk({tag, "_ena"},   32'(ctrl_ena),       0);
        chk({tag, "_done"},  32'(done),           0);
        chk({tag, "_err"},   32'(err),            0);
        chk({tag, "_busy"},  32'(busy),           0);
        chk({tag, "_ready"}, 32'(req_ready),      0);
        chk({tag, "_cur"},   32'(cur_addr),       0);
    endtask

    // Presents one request for one cycle, then samples every cycle after the
    // accepting edge (cycle k = T+k) until done or the budget runs out.
    task automatic do_req(input logic [ADDR_W-1:0] a, input int budget);
        logic p_rst;
        logic p_inc;
        logic p_ena;
        @(negedge clk);
        chk("ready_before_req", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_addr  = a;
        p_rst = ctrl_sel_rst_n;
        p_inc = ctrl_sel_inc;
        p_ena = ctrl_ena;
        r_done_at = 0; r_rst_low = 0; r_rst_first = 0; r_inc_rise = 0;
        r_inc_high = 0; r_ena_low = 0; r_edges = 0;
        r_err1 = 1'bx; r_busy1 = 1'bx; r_cur = 'x; r_ena_done = 1'bx;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = a ^ 8'hA5;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (k == 1) begin
                r_err1  = err;
                r_busy1 = busy;
            end
            if (!ctrl_sel_rst_n) begin
                r_rst_low++;
                if (r_rst_first == 0) r_rst_first = k;
            end
            if (ctrl_sel_inc && !p_inc) r_inc_rise++;
            if (ctrl_sel_inc) r_inc_high++;
            if (!ctrl_ena) r_ena_low++;
            if (ctrl_sel_rst_n !== p_rst || ctrl_sel_inc !== p_inc || ctrl_ena !== p_ena) r_edges++;
            p_rst = ctrl_sel_rst_n;
            p_inc = ctrl_sel_inc;
            p_ena = ctrl_ena;
            if (done) begin
                r_done_at  = k;
                r_cur      = cur_addr;
                r_ena_done = ctrl_ena;
                break;
            end
        end
    endtask

    initial begin
        int rises;
        logic p_inc;

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset("init");
        reset = 1'b0;
        @(negedge clk);
        chk("init_ready_after_reset", 32'(req_ready), 1);
        chk("init_busy_after_reset", 32'(busy), 0);

        // Full sequence to 3: rst_n low T+3..T+4, 3 pulses, done T+19
        do_req(8'd3, 40);
        chk("a3_done_at", r_done_at, 19);
        chk("a3_busy_t1", 32'(r_busy1), 1);
        chk("a3_rst_low_cycles", r_rst_low, 2);
        chk("a3_rst_first", r_rst_first, 3);
        chk("a3_inc_pulses", r_inc_rise, 3);
        chk("a3_inc_high_cycles", r_inc_high, 6);
        chk("a3_ena_low_cycles", r_ena_low, 18);
        chk("a3_ena_at_done", 32'(r_ena_done), 1);
        chk("a3_cur_addr", 32'(r_cur), 3);
        @(negedge clk);
        chk("a3_after_done", 32'(done), 0);
        chk("a3_after_busy", 32'(busy), 0);
        chk("a3_after_ready", 32'(req_ready), 1);
        chk("a3_after_ena", 32'(ctrl_ena), 1);

        // Same address: done at T+1, no control edges
        do_req(8'd3, 10);
        chk("s3_done_at", r_done_at, 1);
        chk("s3_edges", r_edges, 0);
        chk("s3_cur_addr", 32'(r_cur), 3);

        // Incremental 3 -> 5: no rst_n pulse, 2 pulses, done T+11
        do_req(8'd5, 40);
        chk("i5_done_at", r_done_at, 11);
        chk("i5_rst_low_cycles", r_rst_low, 0);
        chk("i5_inc_pulses", r_inc_rise, 2);
        chk("i5_inc_high_cycles", r_inc_high, 4);
        chk("i5_cur_addr", 32'(r_cur), 5);
        @(negedge clk);

        // Backward 5 -> 1: full sequence, 1 pulse, done T+11
        do_req(8'd1, 40);
        chk("f1_done_at", r_done_at, 11);
        chk("f1_rst_low_cycles", r_rst_low, 2);
        chk("f1_rst_first", r_rst_first, 3);
        chk("f1_inc_pulses", r_inc_rise, 1);
        chk("f1_cur_addr", 32'(r_cur), 1);
        @(negedge clk);

        // Out of range 201 > MAX_ADDR: err set, no done, ena held, nothing moves
        do_req(8'd201, 20);
        chk("oor_err_t1", 32'(r_err1), 1);
        chk("oor_busy_t1", 32'(r_busy1), 0);
        chk("oor_no_done", r_done_at, 0);
        chk("oor_edges", r_edges, 0);
        chk("oor_ena_low_cycles", r_ena_low, 0);
        chk("oor_err_sticky", 32'(err), 1);
        chk("oor_cur_addr", 32'(cur_addr), 1);

        // In-range request 1 -> 2 clears err at T+1 (incremental, 1 pulse)
        do_req(8'd2, 40);
        chk("r2_err_t1", 32'(r_err1), 0);
        chk("r2_done_at", r_done_at, 7);
        chk("r2_inc_pulses", r_inc_rise, 1);
        chk("r2_cur_addr", 32'(r_cur), 2);
        @(negedge clk);

        // Address 0: full sequence with zero pulses, done T+7
        do_req(8'd0, 40);
        chk("z0_done_at", r_done_at, 7);
        chk("z0_rst_low_cycles", r_rst_low, 2);
        chk("z0_inc_pulses", r_inc_rise, 0);
        chk("z0_cur_addr", 32'(r_cur), 0);
        @(negedge clk);

        // Incremental 0 -> 10, reset during the 4th INC_HI (cycles T+15..T+16)
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 8'd10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rises = 0;
        p_inc = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (ctrl_sel_inc && !p_inc) rises++;
            p_inc = ctrl_sel_inc;
        end
        chk("mid_inc_high", 32'(ctrl_sel_inc), 1);
        chk("mid_inc_rises", rises, 4);
        reset = 1'b1;
        @(negedge clk);
        chk_reset("mid");
        reset = 1'b0;
        @(negedge clk);
        chk("mid_ready_after_reset", 32'(req_ready), 1);

        // After the abort nothing is known selected: request 2 runs full, done T+15
        do_req(8'd2, 40);
        chk("ar2_done_at", r_done_at, 15);
        chk("ar2_rst_low_cycles", r_rst_low, 2);
        chk("ar2_rst_first", r_rst_first, 3);
        chk("ar2_inc_pulses", r_inc_rise, 2);
        chk("ar2_cur_addr", 32'(r_cur), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
